// File: rtl/fpu_f2i_seq.sv
// Sequential binary32 -> int32/uint32 converter, round toward zero.
// Mantissa is aligned by an iterative shifter moving up to SHIFT_STEP bits per cycle.
module fpu_f2i_seq #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_32_a,
  input  logic        i_signed,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_32_int,
  output logic        o_ov_flag,
  output logic        o_inexact_flag
);

  typedef enum logic [1:0] {StIdle, StShift, StNeg, StDone} state_e;

  localparam logic [4:0] StepW = 5'(SHIFT_STEP);

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sticky_q, sticky_d;
  logic        sign_q, sign_d;
  logic        signed_q, signed_d;
  logic        ov_q, ov_d;
  logic        inx_q, inx_d;

  logic        a_sign;
  logic [7:0]  a_exp;
  logic [22:0] a_man;
  logic        is_special, spec_ov, spec_inx, norm_left;
  logic [31:0] spec_res, shift_mask;
  logic [4:0]  norm_cnt, step;

  assign a_sign = i_32_a[31];
  assign a_exp  = i_32_a[30:23];
  assign a_man  = i_32_a[22:0];

  function automatic logic [31:0] sat_val(input logic neg, input logic sgn);
    if (sgn) return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else     return neg ? 32'h0000_0000 : 32'hFFFF_FFFF;
  endfunction

  // Operand classification; biased exponent 150 means E == 23, 158 means E == 31.
  always_comb begin
    is_special = 1'b1;
    spec_res   = 32'h0;
    spec_ov    = 1'b0;
    spec_inx   = 1'b0;
    norm_left  = (a_exp >= 8'd150);
    norm_cnt   = norm_left ? 5'(a_exp - 8'd150) : 5'(8'd150 - a_exp);
    if (a_exp == 8'd0) begin
      spec_inx = |a_man;
    end else if (a_exp == 8'hFF) begin
      spec_ov  = 1'b1;
      spec_res = (|a_man) ? (i_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)
                          : sat_val(a_sign, i_signed);
    end else if (a_exp < 8'd127) begin
      spec_inx = 1'b1;
    end else if (i_signed &&
                 (a_exp > 8'd158 || (a_exp == 8'd158 && !(a_sign && a_man == 23'd0)))) begin
      spec_ov  = 1'b1;
      spec_res = sat_val(a_sign, 1'b1);
    end else if (!i_signed && (a_exp > 8'd158 || a_sign)) begin
      spec_ov  = 1'b1;
      spec_res = sat_val(a_sign, 1'b0);
    end else begin
      is_special = 1'b0;
    end
  end

  assign step       = (cnt_q > StepW) ? StepW : cnt_q;
  assign shift_mask = ~(32'hFFFF_FFFF << step);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_valid) state_d = is_special ? StDone : ((norm_cnt != 5'd0) ? StShift : StNeg);
      StShift: if (cnt_q == step) state_d = StNeg;
      StNeg:   state_d = StDone;
      StDone:  if (i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready = (state_q == StIdle);
    o_valid = (state_q == StDone);
  end

  always_comb begin
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    signed_d = signed_q;
    ov_d     = ov_q;
    inx_d    = inx_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          sign_d   = a_sign;
          signed_d = i_signed;
          left_d   = norm_left;
          cnt_d    = norm_cnt;
          work_d   = {8'h0, 1'b1, a_man};
          sticky_d = 1'b0;
          if (is_special) begin
            result_d = spec_res;
            ov_d     = spec_ov;
            inx_d    = spec_inx;
          end
        end
      end
      StShift: begin
        work_d   = left_q ? (work_q << step) : (work_q >> step);
        sticky_d = sticky_q | (!left_q && |(work_q & shift_mask));
        cnt_d    = cnt_q - step;
      end
      StNeg: begin
        result_d = (sign_q && signed_q) ? (~work_q + 32'd1) : work_q;
        ov_d     = 1'b0;
        inx_d    = sticky_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      work_q   <= 32'h0;
      result_q <= 32'h0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      signed_q <= 1'b0;
      ov_q     <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      signed_q <= signed_d;
      ov_q     <= ov_d;
      inx_q    <= inx_d;
    end
  end

  assign o_32_int       = result_q;
  assign o_ov_flag      = ov_q;
  assign o_inexact_flag = inx_q;

endmodule

// File: doc/fpu_f2i_seq.md
FPU_F2I_SEQ -- requirements
Module: fpu_f2i_seq

Interface
REQ-001 Parameter: SHIFT_STEP, default 4, maximum mantissa bit positions shifted per cycle; legal values 1, 2, 4, 8.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_valid  input  1  operand valid.
REQ-005 o_ready  output  1  block can accept an operand.
REQ-006 i_32_a  input  32  IEEE-754 binary32 operand.
REQ-007 i_signed  input  1  1 = convert to signed int32; 0 = convert to unsigned uint32. Sampled with i_32_a.
REQ-008 o_valid  output  1  result valid.
REQ-009 i_ready  input  1  downstream accepts the result.
REQ-010 o_32_int  output  32  integer result, rounded toward zero.
REQ-011 o_ov_flag  output  1  operand is NaN, Inf, or out of range; the result is saturated.
REQ-012 o_inexact_flag  output  1  nonzero fraction bits were discarded.

Function
REQ-013 FSM states: IDLE, SHIFT, NEG, DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
REQ-014 Accept: at an edge with i_valid & o_ready, latch the sign, the exponent e, {1,mant[22:0]} and i_signed. Define E = e-127.
REQ-015 Special cases go IDLE->DONE at the accept edge T, so o_valid is high after edge T:
- e==0: result 0, ov 0; inexact = (mant!=0).
- e==255, NaN: ov 1; result 0x7FFFFFFF if signed, 0xFFFFFFFF if unsigned.
- e==255, Inf: ov 1; saturate by sign.
- E<0: result 0, ov 0, inexact 1.
- Signed with E>31, or E==31 except -2^31 exactly: ov 1; saturate by sign.
- Unsigned with E>31: ov 1; saturate by sign.
- Unsigned, negative, E>=0: ov 1; result 0.
REQ-016 Saturation values:
- Signed: positive 0x7FFFFFFF, negative 0x80000000.
- Unsigned: positive 0xFFFFFFFF, negative 0x00000000.
REQ-017 Normal path: shift amount n = |E-23|.
- E>=23: left shift, n in 0..8.
- E<23: right shift, n in 1..23.
- On accept, go to SHIFT if n>0, else to NEG.
REQ-018 SHIFT cycle:
- Shift the 32-bit working register by min(SHIFT_STEP, remaining) and decrement remaining by the same amount.
- On a right shift, OR every bit shifted out into a sticky bit.
- Go to NEG when remaining reaches 0.
REQ-019 NEG: if sign & i_signed, two's-complement the working register. Negative -2^31 yields 0x80000000 with ov 0. Next state DONE. inexact = sticky.
REQ-020 Normal-path latency: o_valid is high after edge T+ceil(n/SHIFT_STEP)+1.
REQ-021 DONE holds o_32_int and both flags stable while i_ready is low. At an edge with o_valid & i_ready, go to IDLE. A new operand is accepted no earlier than the following edge; there is no overlap.
REQ-022 While not in DONE, o_32_int and the flags keep their last values. They are not meaningful until o_valid.
REQ-023 i_valid and i_32_a are ignored while o_ready is low.

Reset
REQ-024 Asserting i_rst at any time, including mid-SHIFT or in DONE, immediately forces:
- state IDLE, o_ready 1, o_valid 0;
- o_32_int 0x00000000, o_ov_flag 0, o_inexact_flag 0;
- working register, shift counter and sticky cleared.
REQ-025 No operand is accepted while i_rst is high. The in-flight operation is discarded and no result is produced for it.

Verification
REQ-026 Normal path, SHIFT_STEP=4: 0x3F800000 (1.0), signed, i_ready=1 -> o_valid after T+7; o_32_int 0x00000001; ov 0; inexact 0.
REQ-027 Rounding toward zero: 0xC0200000 (-2.5), signed -> after T+7: 0xFFFFFFFE; ov 0; inexact 1. Then 0xCF000000 (-2^31), signed -> after T+3: 0x80000000; ov 0.
REQ-028 Specials and range: 0x4F000000 (2^31), signed -> after T: 0x7FFFFFFF, ov 1. Same operand unsigned -> after T+3: 0x80000000, ov 0. 0x7FC00000 (NaN), signed -> 0x7FFFFFFF, ov 1. 0xBF800000 (-1.0), unsigned -> 0x00000000, ov 1.
REQ-029 Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_32_int stable and o_ready 0 throughout. i_ready=1 -> IDLE next edge, and a back-to-back operand is accepted the cycle after.
REQ-030 Reset: assert i_rst during the 3rd SHIFT cycle of 1.0 -> o_valid 0, o_ready 1, outputs 0 immediately. No stale result appears after release. A new 0x40400000 (3.0) yields 0x00000003.
